dbus_arb: RTL and testbench
===========================

Name: dbus_arb

Overview:
- Two-master data-bus arbiter and address decoder for the de0nano SoC.
- Shares the on-chip RAM, the UART and the LED debug register between the cpu32 data port (m0) and a second requester (m1: DMA/debug loader).
- Replaces the ad-hoc cs0/cs1 decode and read-data mux with a sequenced req/ack bus that tolerates multi-cycle RAM read latency.
- Sits between the masters and the aram/uart instances in the top level.

Parameters:
- RAM_AW, 9, RAM word-address width; RAM word address = addr[RAM_AW+1:2].
- RAM_LAT, 1, RAM read latency in clocks (address presented to q valid); legal values 1..4.
- ERR_DATA, 32'h00000000, read data returned for unmapped addresses.

Ports:
- clk  in  1  system clock (CLOCK_50); all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- m0_req  in  1  master 0 request; held with addr/we/wdata until m0_ack.
- m0_addr  in  32  master 0 byte address.
- m0_we  in  1  master 0 write (1) / read (0).
- m0_wdata  in  32  master 0 write data.
- m0_rdata  out  32  master 0 read data; valid only while m0_ack=1.
- m0_ack  out  1  one-cycle completion pulse.
- m1_req, m1_addr, m1_we, m1_wdata, m1_rdata, m1_ack: identical to the m0 set.
- ram_addr  out  RAM_AW  RAM word address.
- ram_wdata  out  32  RAM write data.
- ram_we  out  1  RAM write strobe.
- ram_rdata  in  32  RAM read data.
- uart_we  out  1  UART write strobe.
- uart_wdata  out  32  UART write data.
- uart_rdata  in  8  UART status/read data; zero-extended to 32 bits.
- led  out  8  LED debug register.
- bus_err  out  1  one-cycle pulse when an unmapped access completes.

Behaviour:
- Address decode, on the granted master's addr:
  - RAM: addr[31:16]==16'h0000.
  - UART: addr[31:16]==16'hE000.
  - LED: addr==32'hF0000000.
  - Anything else is unmapped.
- FSM states: IDLE, XFER, WAIT, ACK.
- IDLE:
  - No requests: stay in IDLE.
  - Otherwise latch grant (gnt) and go to XFER.
  - Both requesting: grant the master not served last (round-robin). last_gnt resets to 1, so m0 wins the first tie.
- XFER (exactly one cycle):
  - Drive ram_addr, ram_wdata and uart_wdata from the granted master.
  - Assert ram_we or uart_we for this cycle only if we=1 and that slave is selected.
  - LED write: led <= wdata[7:0] on this edge.
  - Unmapped write: dropped.
  - Next state: WAIT if (RAM read and RAM_LAT>1), else ACK.
- WAIT: hold the address for RAM_LAT-1 cycles (counter), then go to ACK.
- ACK (one cycle):
  - Assert ack to the granted master only; the other master's ack stays 0.
  - rdata = ram_rdata, {24'b0,uart_rdata}, {24'b0,led} or ERR_DATA according to the decode.
  - bus_err=1 if the access is unmapped.
  - Update last_gnt = gnt, then go to IDLE.
- Address/data hold: ram_addr is held from XFER through ACK. uart_rdata may be combinational on the address.
- Latency, req seen in IDLE at cycle 0:
  - Write, UART, LED or unmapped access: ack in cycle 2.
  - RAM read: ack in cycle 1+RAM_LAT.
- Throughput: one transaction per 3+(RAM_LAT-1 for RAM reads) cycles.
- A master holding req through its ack cycle issues a new request, which re-arbitrates in IDLE.
- Request rules:
  - A req dropped before ack is a protocol violation; behaviour is undefined, but the FSM must still complete and return to IDLE.
  - A non-granted master's req, addr and data are ignored.
- Strobes: ram_we and uart_we are never asserted outside XFER, and never both together.
- Reset (asynchronous, including mid-transaction):
  - FSM goes to IDLE; strobes, acks and bus_err go to 0.
  - led=0, last_gnt=1, wait counter=0.
  - The aborted transaction is not acked.
- rdata outputs are 0 whenever the corresponding ack=0.

Decomposition:
- Shared header (dbus_defs.vh): address-map constants (RAM_PAGE 16'h0000, UART_PAGE 16'hE000, LED_ADDR 32'hF0000000) and FSM state encodings. The top level reuses them.
- Sub-module rr_arb2: 2-way round-robin grant from req[1:0] and last_gnt, producing gnt and valid. It is combinational; last_gnt is stored in dbus_arb.

Test Plan:
- m0 write 0x00000010 data 0xCAFEF00D, then read it back (RAM_LAT=1) -> ram_we pulses once with ram_addr=4; read ack in cycle 2 with m0_rdata=0xCAFEF00D; m1_ack stays 0.
- m0 and m1 request at the same cycle after reset, m1 held -> m0 served first, then m1; with both held continuously the acks alternate m0, m1, m0, m1.
- RAM_LAT=3, m1 read RAM -> ack exactly 4 cycles after req; ram_addr stable from XFER through ACK.
- m0 write 0xF0000000 data 0x000000A5, then read it back -> led=0xA5 after the XFER edge; read returns 0x000000A5; no ram_we or uart_we.
- m1 read 0x12340000 -> ack in cycle 2, m1_rdata=ERR_DATA, bus_err one-cycle pulse.
- Assert reset_n=0 during WAIT -> FSM goes to IDLE immediately, led=0, no ack; the first tie after release is won by m0.

Source files
------------

// File: rtl/dbus_arb_pkg.sv
// Shared address map, FSM state type and slave-select decode for the data-bus arbiter.
package dbus_arb_pkg;

  localparam logic [15:0] RAM_PAGE  = 16'h0000;
  localparam logic [15:0] UART_PAGE = 16'hE000;
  localparam logic [31:0] LED_ADDR  = 32'hF0000000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_XFER,
    ST_WAIT,
    ST_ACK
  } state_t;

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_RAM,
    SEL_UART,
    SEL_LED
  } sel_t;

  // Map a byte address onto the slave it selects
  function automatic sel_t decode(input logic [31:0] addr);
    sel_t sel;
    if (addr[31:16] == RAM_PAGE)       sel = SEL_RAM;
    else if (addr[31:16] == UART_PAGE) sel = SEL_UART;
    else if (addr == LED_ADDR)         sel = SEL_LED;
    else                               sel = SEL_NONE;
    return sel;
  endfunction

endpackage

// File: rtl/dbus_arb_if.sv
// Data-bus bundle: both master request ports plus the RAM and UART slave sides.
// The slave modport is the arbiter's view; master is the view of the surrounding system.
interface dbus_arb_if #(
  parameter int unsigned RAM_AW = 9
) ();

  logic              m0_req;
  logic [31:0]       m0_addr;
  logic              m0_we;
  logic [31:0]       m0_wdata;
  logic [31:0]       m0_rdata;
  logic              m0_ack;

  logic              m1_req;
  logic [31:0]       m1_addr;
  logic              m1_we;
  logic [31:0]       m1_wdata;
  logic [31:0]       m1_rdata;
  logic              m1_ack;

  logic [RAM_AW-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic              ram_we;
  logic [31:0]       ram_rdata;

  logic              uart_we;
  logic [31:0]       uart_wdata;
  logic [7:0]        uart_rdata;

  modport slave (
    input  m0_req, m0_addr, m0_we, m0_wdata,
    output m0_rdata, m0_ack,
    input  m1_req, m1_addr, m1_we, m1_wdata,
    output m1_rdata, m1_ack,
    output ram_addr, ram_wdata, ram_we,
    input  ram_rdata,
    output uart_we, uart_wdata,
    input  uart_rdata
  );

  modport master (
    output m0_req, m0_addr, m0_we, m0_wdata,
    input  m0_rdata, m0_ack,
    output m1_req, m1_addr, m1_we, m1_wdata,
    input  m1_rdata, m1_ack,
    input  ram_addr, ram_wdata, ram_we,
    output ram_rdata,
    input  uart_we, uart_wdata,
    output uart_rdata
  );

endinterface

// File: rtl/dbus_arb_rr_arb2.sv
// Two-way round-robin grant: on a tie the master not served last wins.
module rr_arb2 (
  input  logic [1:0] i_req,
  input  logic       i_last_gnt,
  output logic       o_gnt,
  output logic       o_valid
);

  // Grant selection from the current requests and the previous winner
  always_comb begin
    o_valid = |i_req;
    o_gnt   = 1'b0;
    case (i_req)
      2'b01:   o_gnt = 1'b0;
      2'b10:   o_gnt = 1'b1;
      2'b11:   o_gnt = ~i_last_gnt;
      default: o_gnt = 1'b0;
    endcase
  end

endmodule

// File: rtl/dbus_arb.sv
// Two-master data-bus arbiter and address decoder (RAM / UART / LED register).
// The granted master's request is captured in IDLE, so the slave side sees a stable
// address and data from XFER through ACK even if the master misbehaves.
module dbus_arb
  import dbus_arb_pkg::*;
#(
  parameter int unsigned RAM_AW   = 9,
  parameter int unsigned RAM_LAT  = 1,
  parameter logic [31:0] ERR_DATA = 32'h00000000
) (
  input  logic        clk,
  input  logic        reset_n,
  dbus_arb_if.slave   bus,
  output logic [7:0]  led,
  output logic        bus_err
);

  localparam logic [1:0] WAIT_INIT = 2'((RAM_LAT > 1) ? (RAM_LAT - 2) : 0);

  state_t      r_state;
  state_t      w_next;
  logic        r_gnt;
  logic        r_last_gnt;
  logic [31:0] r_addr;
  logic        r_we;
  logic [31:0] r_wdata;
  logic [1:0]  r_cnt;
  logic [7:0]  r_led;

  logic        w_gnt;
  logic        w_valid;
  sel_t        w_sel;
  logic [31:0] w_rdata;

  rr_arb2 u_rr_arb2 (
    .i_req      ({bus.m1_req, bus.m0_req}),
    .i_last_gnt (r_last_gnt),
    .o_gnt      (w_gnt),
    .o_valid    (w_valid)
  );

  assign w_sel          = decode(r_addr);
  assign bus.ram_addr   = r_addr[RAM_AW+1:2];
  assign bus.ram_wdata  = r_wdata;
  assign bus.uart_wdata = r_wdata;
  assign led            = r_led;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_valid) w_next = ST_XFER;
      ST_XFER: w_next = (!r_we && (w_sel == SEL_RAM) && (RAM_LAT > 1)) ? ST_WAIT : ST_ACK;
      ST_WAIT: if (r_cnt == '0) w_next = ST_ACK;
      ST_ACK:  w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Request capture, LED register, wait counter and round-robin history
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_gnt      <= 1'b0;
      r_last_gnt <= 1'b1;
      r_addr     <= '0;
      r_we       <= 1'b0;
      r_wdata    <= '0;
      r_cnt      <= '0;
      r_led      <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (w_valid) begin
          r_gnt   <= w_gnt;
          r_addr  <= w_gnt ? bus.m1_addr  : bus.m0_addr;
          r_we    <= w_gnt ? bus.m1_we    : bus.m0_we;
          r_wdata <= w_gnt ? bus.m1_wdata : bus.m0_wdata;
        end
        ST_XFER: begin
          r_cnt <= WAIT_INIT;
          if (r_we && (w_sel == SEL_LED)) r_led <= r_wdata[7:0];
        end
        ST_WAIT: if (r_cnt != '0) r_cnt <= r_cnt - 2'd1;
        ST_ACK:  r_last_gnt <= r_gnt;
        default: ;
      endcase
    end
  end

  // Read-data selection from the decoded slave
  always_comb begin
    w_rdata = ERR_DATA;
    case (w_sel)
      SEL_RAM:  w_rdata = bus.ram_rdata;
      SEL_UART: w_rdata = {24'b0, bus.uart_rdata};
      SEL_LED:  w_rdata = {24'b0, r_led};
      default:  w_rdata = ERR_DATA;
    endcase
  end

  // Strobes, acks, gated read data and error pulse
  always_comb begin
    bus.ram_we   = 1'b0;
    bus.uart_we  = 1'b0;
    bus.m0_ack   = 1'b0;
    bus.m1_ack   = 1'b0;
    bus.m0_rdata = '0;
    bus.m1_rdata = '0;
    bus_err      = 1'b0;
    if (r_state == ST_XFER) begin
      bus.ram_we  = r_we && (w_sel == SEL_RAM);
      bus.uart_we = r_we && (w_sel == SEL_UART);
    end
    if (r_state == ST_ACK) begin
      bus.m0_ack = ~r_gnt;
      bus.m1_ack = r_gnt;
      if (r_gnt) bus.m1_rdata = w_rdata;
      else       bus.m0_rdata = w_rdata;
      bus_err = (w_sel == SEL_NONE);
    end
  end

endmodule

// File: tb/tb_dbus_arb.sv
// Directed bench for dbus_arb: instance a uses RAM_LAT=1, instance b uses RAM_LAT=3.
module tb_dbus_arb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, rst_b;
  logic [7:0] led_a, led_b;
  logic       err_a, err_b;

  dbus_arb_if #(.RAM_AW(9)) bus_a ();
  dbus_arb_if #(.RAM_AW(9)) bus_b ();

  dbus_arb #(.RAM_AW(9), .RAM_LAT(1), .ERR_DATA(32'hDEADBEEF)) dut_a (
    .clk(clk), .reset_n(rst_a), .bus(bus_a), .led(led_a), .bus_err(err_a)
  );
  dbus_arb #(.RAM_AW(9), .RAM_LAT(3), .ERR_DATA(32'h00000000)) dut_b (
    .clk(clk), .reset_n(rst_b), .bus(bus_b), .led(led_b), .bus_err(err_b)
  );

  // Synchronous RAM models: one-cycle for a, three-stage pipeline for b
  logic [31:0] mem_a [512];
  logic [31:0] mem_b [512];
  logic [31:0] q_a, p1_b, p2_b, p3_b;

  always @(posedge clk) begin
    if (bus_a.ram_we) mem_a[bus_a.ram_addr] <= bus_a.ram_wdata;
    q_a <= mem_a[bus_a.ram_addr];
    if (bus_b.ram_we) mem_b[bus_b.ram_addr] <= bus_b.ram_wdata;
    p1_b <= mem_b[bus_b.ram_addr];
    p2_b <= p1_b;
    p3_b <= p2_b;
  end

  assign bus_a.ram_rdata  = q_a;
  assign bus_b.ram_rdata  = p3_b;
  assign bus_a.uart_rdata = 8'h5A;
  assign bus_b.uart_rdata = 8'hC3;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic ack_of(input int d, input int m);
    if (d == 0) return (m == 0) ? bus_a.m0_ack : bus_a.m1_ack;
    return (m == 0) ? bus_b.m0_ack : bus_b.m1_ack;
  endfunction

  function automatic logic [31:0] rdata_of(input int d, input int m);
    if (d == 0) return (m == 0) ? bus_a.m0_rdata : bus_a.m1_rdata;
    return (m == 0) ? bus_b.m0_rdata : bus_b.m1_rdata;
  endfunction

  function automatic logic ramwe_of(input int d);
    return (d == 0) ? bus_a.ram_we : bus_b.ram_we;
  endfunction

  function automatic logic uartwe_of(input int d);
    return (d == 0) ? bus_a.uart_we : bus_b.uart_we;
  endfunction

  function automatic logic err_of(input int d);
    return (d == 0) ? err_a : err_b;
  endfunction

  function automatic logic [8:0] ramaddr_of(input int d);
    return (d == 0) ? bus_a.ram_addr : bus_b.ram_addr;
  endfunction

  function automatic logic [31:0] ramwd_of(input int d);
    return (d == 0) ? bus_a.ram_wdata : bus_b.ram_wdata;
  endfunction

  function automatic logic [31:0] uartwd_of(input int d);
    return (d == 0) ? bus_a.uart_wdata : bus_b.uart_wdata;
  endfunction

  task automatic drv(input int d, input int m, input logic req, input logic [31:0] addr,
                     input logic we, input logic [31:0] wd);
    if (d == 0 && m == 0) begin
      bus_a.m0_req = req; bus_a.m0_addr = addr; bus_a.m0_we = we; bus_a.m0_wdata = wd;
    end else if (d == 0) begin
      bus_a.m1_req = req; bus_a.m1_addr = addr; bus_a.m1_we = we; bus_a.m1_wdata = wd;
    end else if (m == 0) begin
      bus_b.m0_req = req; bus_b.m0_addr = addr; bus_b.m0_we = we; bus_b.m0_wdata = wd;
    end else begin
      bus_b.m1_req = req; bus_b.m1_addr = addr; bus_b.m1_we = we; bus_b.m1_wdata = wd;
    end
  endtask

  // Observations from the latest single-master transaction
  logic [31:0] t_rd, t_wval;
  logic [8:0]  t_waddr;
  int          t_lat, t_rwe, t_uwe, t_errc, t_oth, t_astab, t_post;

  // Called just after a rising edge with the arbiter idle; req is seen in cycle 0
  task automatic txn(input int d, input int m, input logic [31:0] addr,
                     input logic we, input logic [31:0] wd);
    logic [8:0] exp_wa;
    exp_wa = addr[10:2];
    t_rd = '0; t_wval = '0; t_waddr = '0;
    t_lat = -1; t_rwe = 0; t_uwe = 0; t_errc = 0; t_oth = 0; t_astab = 0; t_post = 0;
    drv(d, m, 1'b1, addr, we, wd);
    for (int c = 0; c < 20 && t_lat < 0; c++) begin
      @(negedge clk);
      if (ramwe_of(d)) begin t_rwe++; t_waddr = ramaddr_of(d); t_wval = ramwd_of(d); end
      if (uartwe_of(d)) begin t_uwe++; t_wval = uartwd_of(d); end
      if (err_of(d)) t_errc++;
      if (ack_of(d, 1 - m)) t_oth++;
      if (c >= 1 && ramaddr_of(d) != exp_wa) t_astab++;
      if (ack_of(d, m)) begin t_lat = c; t_rd = rdata_of(d, m); end
    end
    @(posedge clk); #1;
    drv(d, m, 1'b0, '0, 1'b0, '0);
    @(negedge clk);
    t_post = int'(ack_of(d, m)) + int'(err_of(d)) + int'(rdata_of(d, m) != 0);
    @(posedge clk); #1;
  endtask

  // Both masters request together and hold; acks must alternate starting with m0
  task automatic tie(input int d, input string tag, input logic [31:0] exp_m0, input logic [31:0] exp_m1);
    int          who [4];
    int          cyc [4];
    logic [31:0] rdv [4];
    int          n, both;
    n = 0; both = 0;
    for (int i = 0; i < 4; i++) begin who[i] = 9; cyc[i] = -1; rdv[i] = '0; end
    drv(d, 0, 1'b1, 32'hF0000000, 1'b0, '0);
    drv(d, 1, 1'b1, 32'hE0000000, 1'b0, '0);
    for (int c = 0; c < 40 && n < 4; c++) begin
      @(negedge clk);
      if (ack_of(d, 0) && ack_of(d, 1)) both++;
      else if (ack_of(d, 0)) begin who[n] = 0; cyc[n] = c; rdv[n] = rdata_of(d, 0); n++; end
      else if (ack_of(d, 1)) begin who[n] = 1; cyc[n] = c; rdv[n] = rdata_of(d, 1); n++; end
    end
    @(posedge clk); #1;
    drv(d, 0, 1'b0, '0, 1'b0, '0);
    drv(d, 1, 1'b0, '0, 1'b0, '0);
    @(negedge clk);
    @(posedge clk); #1;
    chk($sformatf("%s_nacks", tag), n, 4);
    chk($sformatf("%s_dual_ack", tag), both, 0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s_who%0d", tag, i), who[i], i % 2);
      chk($sformatf("%s_cyc%0d", tag, i), cyc[i], 2 + 3 * i);
      chk($sformatf("%s_rd%0d", tag, i), rdv[i], (i % 2 == 0) ? exp_m0 : exp_m1);
    end
  endtask

  initial begin
    int nack;
    rst_a = 1'b0;
    rst_b = 1'b0;
    for (int d = 0; d < 2; d++)
      for (int m = 0; m < 2; m++) drv(d, m, 1'b0, '0, 1'b0, '0);

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_m0_ack", bus_a.m0_ack, 0);
    chk("rst_m1_ack", bus_a.m1_ack, 0);
    chk("rst_m0_rdata", bus_a.m0_rdata, 0);
    chk("rst_led", led_a, 0);
    chk("rst_bus_err", err_a, 0);
    chk("rst_strobes", {bus_a.ram_we, bus_a.uart_we}, 0);
    rst_a = 1'b1;
    rst_b = 1'b1;
    @(posedge clk); #1;

    // First tie after reset goes to m0, then strict alternation
    tie(0, "tie_a", 32'h0, 32'h5A);

    // RAM write then read back, LAT=1
    txn(0, 0, 32'h00000010, 1'b1, 32'hCAFEF00D);
    chk("wr_lat", t_lat, 2);
    chk("wr_ram_we_cnt", t_rwe, 1);
    chk("wr_ram_addr", t_waddr, 4);
    chk("wr_ram_wdata", t_wval, 32'hCAFEF00D);
    chk("wr_uart_we_cnt", t_uwe, 0);
    chk("wr_m1_ack", t_oth, 0);
    txn(0, 0, 32'h00000010, 1'b0, '0);
    chk("rd_lat", t_lat, 2);
    chk("rd_data", t_rd, 32'hCAFEF00D);
    chk("rd_ram_we_cnt", t_rwe, 0);
    chk("rd_m1_ack", t_oth, 0);
    chk("rd_post_idle", t_post, 0);

    // LED register write and read back
    txn(0, 0, 32'hF0000000, 1'b1, 32'h000000A5);
    chk("led_wr_lat", t_lat, 2);
    chk("led_value", led_a, 8'hA5);
    chk("led_wr_strobes", t_rwe + t_uwe, 0);
    txn(0, 0, 32'hF0000000, 1'b0, '0);
    chk("led_rd_data", t_rd, 32'h000000A5);
    chk("led_rd_strobes", t_rwe + t_uwe, 0);

    // UART write and read from m1
    txn(0, 1, 32'hE0000004, 1'b1, 32'h00000041);
    chk("uart_wr_lat", t_lat, 2);
    chk("uart_we_cnt", t_uwe, 1);
    chk("uart_wdata", t_wval, 32'h00000041);
    chk("uart_wr_ram_we", t_rwe, 0);
    chk("uart_wr_m0_ack", t_oth, 0);
    txn(0, 1, 32'hE0000008, 1'b0, '0);
    chk("uart_rd_data", t_rd, 32'h0000005A);

    // Unmapped accesses
    txn(0, 1, 32'h12340000, 1'b0, '0);
    chk("unm_rd_lat", t_lat, 2);
    chk("unm_rd_data", t_rd, 32'hDEADBEEF);
    chk("unm_rd_err_cnt", t_errc, 1);
    chk("unm_rd_post_idle", t_post, 0);
    txn(0, 1, 32'hF0000004, 1'b1, 32'h00000077);
    chk("unm_wr_err_cnt", t_errc, 1);
    chk("unm_wr_strobes", t_rwe + t_uwe, 0);
    chk("unm_wr_led_kept", led_a, 8'hA5);

    // m1 reads the word m0 wrote
    txn(0, 1, 32'h00000010, 1'b0, '0);
    chk("m1_rd_data", t_rd, 32'hCAFEF00D);
    chk("m1_rd_err", t_errc, 0);

    // RAM_LAT=3 instance
    txn(1, 1, 32'h00000020, 1'b1, 32'h11223344);
    chk("l3_wr_lat", t_lat, 2);
    chk("l3_wr_ram_addr", t_waddr, 8);
    chk("l3_wr_ram_we_cnt", t_rwe, 1);
    txn(1, 1, 32'h00000020, 1'b0, '0);
    chk("l3_rd_lat", t_lat, 4);
    chk("l3_rd_data", t_rd, 32'h11223344);
    chk("l3_addr_hold", t_astab, 0);
    chk("l3_rd_m0_ack", t_oth, 0);
    txn(1, 0, 32'hF0000000, 1'b1, 32'h0000003C);
    chk("l3_led_value", led_b, 8'h3C);

    // Reset asserted while the RAM read sits in WAIT
    drv(1, 0, 1'b1, 32'h00000020, 1'b0, '0);
    repeat (3) @(negedge clk);
    chk("wait_no_ack_yet", bus_b.m0_ack, 0);
    #1 rst_b = 1'b0;
    #1;
    chk("arst_led", led_b, 0);
    chk("arst_acks", {bus_b.m0_ack, bus_b.m1_ack}, 0);
    chk("arst_strobes", {bus_b.ram_we, bus_b.uart_we, err_b}, 0);
    drv(1, 0, 1'b0, '0, 1'b0, '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_b = 1'b1;
    nack = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (bus_b.m0_ack || bus_b.m1_ack) nack++;
    end
    chk("arst_no_late_ack", nack, 0);
    @(posedge clk); #1;
    tie(1, "tie_b", 32'h0, 32'hC3);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
